lmb_bram_port_ctrl: RTL and testbench

LMB_BRAM_PORT_CTRL -- requirements
Module: lmb_bram_port_ctrl

---
 rtl/lmb_bram_port_ctrl_pkg.sv | 29 ++
 rtl/lmb_rsp_fifo.sv | 76 +++++++
 rtl/lmb_bram_port_ctrl.sv | 118 +++++++++++
 tb/tb_lmb_bram_port_ctrl.sv | 382 ++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/lmb_bram_port_ctrl_pkg.sv
// Shared definitions for the LMB BRAM port controller and the BRAM block:
// default address map, derived widths and response-record layout.
package lmb_bram_port_ctrl_pkg;

  localparam logic [31:0] LMB_DEF_BASEADDR = 32'h0000_0000;
  localparam logic [31:0] LMB_DEF_HIGHADDR = 32'h0000_7FFF;
  localparam logic [31:0] LMB_DEF_MEMSIZE  = 32'h0000_8000;

  localparam int LMB_DEF_AWIDTH = 32;
  localparam int LMB_DEF_DWIDTH = 32;
  localparam int LMB_DEF_NUM_WE = 4;

  // Number of byte-offset address bits cleared to form a word address.
  localparam int LMB_ADDR_LSB_BITS = 2;

  // Response FIFO depth; the controller's flow control assumes exactly two.
  localparam int LMB_RSP_FIFO_DEPTH = 2;

  // Width of one byte lane given the data width and number of write enables.
  function automatic int lmbLaneWidth(input int dWidth, input int numWe);
    return dWidth / numWe;
  endfunction

  // A response record is the read data plus one error flag in the MSB.
  function automatic int lmbRspRecWidth(input int dWidth);
    return dWidth + 1;
  endfunction

endpackage

// File: rtl/lmb_rsp_fifo.sv
// Two-entry response FIFO. Entry 0 is always the head, so the output is a
// plain register. Push and pop in the same cycle are allowed at any fill level
// that makes them legal, without losing or reordering records.
module lmb_rsp_fifo
  import lmb_bram_port_ctrl_pkg::*;
#(
  parameter int WIDTH = 33
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             push_i,
  input  logic [WIDTH-1:0] pushData_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] head_o,
  output logic [1:0]       count_o
);

  localparam logic [1:0] FULL_COUNT = 2'(LMB_RSP_FIFO_DEPTH);

  logic [WIDTH-1:0] entry0_q, entry0_d;
  logic [WIDTH-1:0] entry1_q, entry1_d;
  logic [1:0]       count_q, count_d;
  logic             doPop;
  logic             doPush;

  assign doPop   = pop_i && (count_q != 2'd0);
  assign doPush  = push_i && ((count_q != FULL_COUNT) || doPop);
  assign head_o  = entry0_q;
  assign count_o = count_q;

  // Next-state: popping shifts entry 1 into the head; a push lands in the
  // first slot that is free after any simultaneous pop.
  always_comb begin
    entry0_d = entry0_q;
    entry1_d = entry1_q;
    count_d  = count_q;
    case ({doPush, doPop})
      2'b01: begin
        entry0_d = entry1_q;
        count_d  = count_q - 2'd1;
      end
      2'b10: begin
        if (count_q == 2'd0) begin
          entry0_d = pushData_i;
        end else begin
          entry1_d = pushData_i;
        end
        count_d = count_q + 2'd1;
      end
      2'b11: begin
        if (count_q == 2'd1) begin
          entry0_d = pushData_i;
        end else begin
          entry0_d = entry1_q;
          entry1_d = pushData_i;
        end
      end
      default: begin
      end
    endcase
  end

  // Storage and fill level; reset empties the FIFO immediately.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      entry0_q <= '0;
      entry1_q <= '0;
      count_q  <= 2'd0;
    end else begin
      entry0_q <= entry0_d;
      entry1_q <= entry1_d;
      count_q  <= count_d;
    end
  end

endmodule

// File: rtl/lmb_bram_port_ctrl.sv
// LMB-style request/response front end for a single BRAM port. Requests are
// decoded against the address window and forwarded to the BRAM in the accept
// cycle; the one-cycle BRAM read result is collected into a two-entry FIFO
// that feeds the response channel in request order.
module lmb_bram_port_ctrl
  import lmb_bram_port_ctrl_pkg::*;
#(
  parameter int                       C_PORT_AWIDTH = LMB_DEF_AWIDTH,
  parameter int                       C_PORT_DWIDTH = LMB_DEF_DWIDTH,
  parameter int                       C_NUM_WE      = LMB_DEF_NUM_WE,
  parameter logic [0:C_PORT_AWIDTH-1] C_BASEADDR    = LMB_DEF_BASEADDR,
  parameter logic [0:C_PORT_AWIDTH-1] C_HIGHADDR    = LMB_DEF_HIGHADDR
) (
  input  logic                     LMB_Clk,
  input  logic                     LMB_Rst_N,
  input  logic                     Req_Valid,
  output logic                     Req_Ready,
  input  logic                     Req_Write,
  input  logic [0:C_PORT_AWIDTH-1] Req_Addr,
  input  logic [0:C_NUM_WE-1]      Req_BE,
  input  logic [0:C_PORT_DWIDTH-1] Req_WData,
  output logic                     Rsp_Valid,
  input  logic                     Rsp_Ready,
  output logic [0:C_PORT_DWIDTH-1] Rsp_RData,
  output logic                     Rsp_Err,
  output logic                     BRAM_Clk,
  output logic                     BRAM_Rst,
  output logic                     BRAM_EN,
  output logic [0:C_NUM_WE-1]      BRAM_WEN,
  output logic [0:C_PORT_AWIDTH-1] BRAM_Addr,
  output logic [0:C_PORT_DWIDTH-1] BRAM_Dout,
  input  logic [0:C_PORT_DWIDTH-1] BRAM_Din
);

  localparam int RSP_W = lmbRspRecWidth(C_PORT_DWIDTH);

  // Window test as a single unsigned compare of the offset from the base, so
  // addresses below the base wrap to large offsets and fall outside.
  localparam logic [0:C_PORT_AWIDTH-1] ADDR_SPAN = C_HIGHADDR - C_BASEADDR;

  logic [0:C_PORT_AWIDTH-1] addrOffset;
  logic                     hit;
  logic                     accept;
  logic                     acceptHit;
  logic                     rspPop;
  logic [2:0]               occupancy;

  logic                     infValid_q, infValid_d;
  logic                     infWrite_q, infWrite_d;
  logic                     infErr_q, infErr_d;

  logic [0:C_PORT_DWIDTH-1] pushRData;
  logic [RSP_W-1:0]         pushRec;
  logic [RSP_W-1:0]         fifoHead;
  logic [1:0]               fifoCount;

  assign addrOffset = Req_Addr - C_BASEADDR;
  assign hit        = (addrOffset <= ADDR_SPAN);

  // A slot is reserved for every request between accept and response. A pop
  // in the current cycle frees a slot, which is what lets the port stream one
  // request per cycle while the consumer keeps up. Held low during reset so
  // nothing reaches the BRAM.
  assign rspPop    = Rsp_Valid && Rsp_Ready;
  assign occupancy = {1'b0, fifoCount} + {2'b00, infValid_q};
  assign Req_Ready = LMB_Rst_N && ((occupancy - {2'b00, rspPop}) < 3'd2);

  assign accept    = Req_Valid && Req_Ready;
  assign acceptHit = accept && hit;

  assign BRAM_Clk  = LMB_Clk;
  assign BRAM_Rst  = ~LMB_Rst_N;
  assign BRAM_EN   = acceptHit;
  assign BRAM_WEN  = (acceptHit && Req_Write) ? Req_BE : '0;
  assign BRAM_Addr = {Req_Addr[0:C_PORT_AWIDTH-LMB_ADDR_LSB_BITS-1], {LMB_ADDR_LSB_BITS{1'b0}}};
  assign BRAM_Dout = Req_WData;

  // Capture what kind of request was accepted so its response can be built
  // when the BRAM data arrives one cycle later.
  always_comb begin
    infValid_d = accept;
    infWrite_d = accept ? Req_Write : infWrite_q;
    infErr_d   = accept ? !hit : infErr_q;
  end

  // In-flight record register; reset drops any request accepted this cycle.
  always_ff @(posedge LMB_Clk or negedge LMB_Rst_N) begin
    if (!LMB_Rst_N) begin
      infValid_q <= 1'b0;
      infWrite_q <= 1'b0;
      infErr_q   <= 1'b0;
    end else begin
      infValid_q <= infValid_d;
      infWrite_q <= infWrite_d;
      infErr_q   <= infErr_d;
    end
  end

  assign pushRData = (infValid_q && !infWrite_q && !infErr_q) ? BRAM_Din : '0;
  assign pushRec   = {infErr_q, pushRData};

  lmb_rsp_fifo #(
    .WIDTH(RSP_W)
  ) u_rsp_fifo (
    .clk_i      (LMB_Clk),
    .rst_ni     (LMB_Rst_N),
    .push_i     (infValid_q),
    .pushData_i (pushRec),
    .pop_i      (rspPop),
    .head_o     (fifoHead),
    .count_o    (fifoCount)
  );

  assign Rsp_Valid = (fifoCount != 2'd0);
  assign Rsp_Err   = Rsp_Valid && fifoHead[RSP_W-1];
  assign Rsp_RData = Rsp_Valid ? fifoHead[C_PORT_DWIDTH-1:0] : '0;

endmodule

// File: tb/tb_lmb_bram_port_ctrl.sv
// Self-checking bench for lmb_bram_port_ctrl. A behavioural BRAM sits on the
// port; a word-array reference model predicts every response at accept time
// and a monitor compares responses in order as they are consumed.
module tb_lmb_bram_port_ctrl;

  localparam logic [31:0] BASE = 32'h0000_0000;
  localparam logic [31:0] HIGH = 32'h0000_7FFF;

  logic        LMB_Clk   = 1'b0;
  logic        LMB_Rst_N = 1'b0;
  logic        Req_Valid = 1'b0;
  logic        Req_Ready;
  logic        Req_Write = 1'b0;
  logic [0:31] Req_Addr  = '0;
  logic [0:3]  Req_BE    = '0;
  logic [0:31] Req_WData = '0;
  logic        Rsp_Valid;
  logic        Rsp_Ready = 1'b0;
  logic [0:31] Rsp_RData;
  logic        Rsp_Err;
  logic        BRAM_Clk;
  logic        BRAM_Rst;
  logic        BRAM_EN;
  logic [0:3]  BRAM_WEN;
  logic [0:31] BRAM_Addr;
  logic [0:31] BRAM_Dout;
  logic [0:31] BRAM_Din  = '0;

  lmb_bram_port_ctrl #(
    .C_PORT_AWIDTH(32),
    .C_PORT_DWIDTH(32),
    .C_NUM_WE     (4),
    .C_BASEADDR   (BASE),
    .C_HIGHADDR   (HIGH)
  ) dut (
    .LMB_Clk   (LMB_Clk),
    .LMB_Rst_N (LMB_Rst_N),
    .Req_Valid (Req_Valid),
    .Req_Ready (Req_Ready),
    .Req_Write (Req_Write),
    .Req_Addr  (Req_Addr),
    .Req_BE    (Req_BE),
    .Req_WData (Req_WData),
    .Rsp_Valid (Rsp_Valid),
    .Rsp_Ready (Rsp_Ready),
    .Rsp_RData (Rsp_RData),
    .Rsp_Err   (Rsp_Err),
    .BRAM_Clk  (BRAM_Clk),
    .BRAM_Rst  (BRAM_Rst),
    .BRAM_EN   (BRAM_EN),
    .BRAM_WEN  (BRAM_WEN),
    .BRAM_Addr (BRAM_Addr),
    .BRAM_Dout (BRAM_Dout),
    .BRAM_Din  (BRAM_Din)
  );

  always #5 LMB_Clk = ~LMB_Clk;

  typedef struct {
    logic        err;
    logic [31:0] rdata;
  } exp_t;

  exp_t expQ[$];
  int   checks = 0;
  int   errors = 0;
  int   cycle = 0;
  int   acceptCount = 0;
  int   rspCount = 0;
  int   acceptCycles[$];
  int   rspCycles[$];
  int   rdyMode = 1;

  logic [31:0] refMem  [0:8191] = '{default: 32'h0};
  logic [31:0] bramMem [0:8191] = '{default: 32'h0};

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  always @(posedge LMB_Clk) cycle <= cycle + 1;

  // Response-ready driver: 0 = hold off, 1 = always ready, 2 = random.
  initial forever begin
    @(posedge LMB_Clk);
    #2;
    case (rdyMode)
      0:       Rsp_Ready = 1'b0;
      1:       Rsp_Ready = 1'b1;
      default: Rsp_Ready = ($urandom_range(3) != 0);
    endcase
  end

  // Behavioural BRAM with one-cycle read latency; port signals captured
  // mid-cycle and applied on the rising edge.
  logic        bEn = 1'b0;
  logic [0:3]  bWen = '0;
  logic [31:0] bAddr = '0;
  logic [31:0] bDout = '0;

  always @(negedge LMB_Clk) begin
    bEn   <= BRAM_EN;
    bWen  <= BRAM_WEN;
    bAddr <= BRAM_Addr;
    bDout <= BRAM_Dout;
  end

  always @(posedge LMB_Clk) begin
    if (bEn) begin
      BRAM_Din <= bramMem[bAddr[14:2]];
      for (int i = 0; i < 4; i++) begin
        if (bWen[i]) bramMem[bAddr[14:2]][31-8*i -: 8] <= bDout[31-8*i -: 8];
      end
    end
  end

  // A reset forgets every outstanding response.
  initial forever begin
    @(negedge LMB_Rst_N);
    expQ.delete();
  end

  // Monitor: consume responses against the scoreboard, check the BRAM port
  // against the decode rules and predict the response for each accept.
  task automatic monitorStep();
    logic        acc;
    logic        hitM;
    logic [31:0] a;
    logic [31:0] wd;
    logic [31:0] w;
    logic [3:0]  expWen;
    exp_t        e;
    if (!LMB_Rst_N) return;
    if (Rsp_Valid && Rsp_Ready) begin
      rspCount++;
      rspCycles.push_back(cycle);
      if (expQ.size() == 0) begin
        checks++;
        errors++;
        $display("[TB] FAIL unexpected_rsp: got response err=%0b data=0x%0h, expected none", Rsp_Err, Rsp_RData);
      end else begin
        e = expQ.pop_front();
        checkOutput("rsp_err", Rsp_Err, e.err);
        checkOutput("rsp_rdata", Rsp_RData, e.rdata);
      end
    end
    a    = Req_Addr;
    wd   = Req_WData;
    acc  = Req_Valid && Req_Ready;
    hitM = (longint'(a) >= longint'(BASE)) && (longint'(a) <= longint'(HIGH));
    expWen = (acc && hitM && Req_Write) ? Req_BE : 4'b0000;
    checkOutput("bram_en", BRAM_EN, acc && hitM);
    checkOutput("bram_wen", BRAM_WEN, expWen);
    if (acc && hitM) begin
      checkOutput("bram_addr", BRAM_Addr, a & 32'hFFFF_FFFC);
      checkOutput("bram_dout", BRAM_Dout, wd);
    end
    if (acc) begin
      acceptCount++;
      acceptCycles.push_back(cycle);
      if (!hitM) begin
        e.err = 1'b1;
        e.rdata = 32'h0;
      end else if (Req_Write) begin
        w = refMem[a[14:2]];
        for (int i = 0; i < 4; i++) begin
          if (Req_BE[i]) w[31-8*i -: 8] = wd[31-8*i -: 8];
        end
        refMem[a[14:2]] = w;
        e.err = 1'b0;
        e.rdata = 32'h0;
      end else begin
        e.err = 1'b0;
        e.rdata = refMem[a[14:2]];
      end
      expQ.push_back(e);
    end
  endtask

  initial forever begin
    @(negedge LMB_Clk);
    monitorStep();
  end

  // Present one request and hold it until accepted, then drop valid.
  task automatic applyStimulus(input logic wr, input logic [31:0] addr,
                               input logic [3:0] be, input logic [31:0] wd);
    int waitCyc = 0;
    Req_Valid = 1'b1;
    Req_Write = wr;
    Req_Addr  = addr;
    Req_BE    = be;
    Req_WData = wd;
    forever begin
      @(negedge LMB_Clk);
      if (Req_Ready) break;
      waitCyc++;
      if (waitCyc > 200) begin
        checks++;
        errors++;
        $display("[TB] FAIL req_timeout: request at 0x%0h never accepted", addr);
        break;
      end
    end
    @(posedge LMB_Clk);
    #1;
    Req_Valid = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge LMB_Clk);
    #1;
  endtask

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int a0;
    int r0;
    int waitCyc;
    logic [31:0] addr;
    int r;

    // Reset state, with a write request pending that must not reach the BRAM.
    Req_Valid = 1'b1;
    Req_Write = 1'b1;
    Req_BE    = 4'hF;
    #12;
    checkOutput("rst_rsp_valid", Rsp_Valid, 0);
    checkOutput("rst_rsp_err", Rsp_Err, 0);
    checkOutput("rst_rsp_rdata", Rsp_RData, 0);
    checkOutput("rst_bram_en", BRAM_EN, 0);
    checkOutput("rst_bram_wen", BRAM_WEN, 0);
    checkOutput("rst_bram_rst", BRAM_Rst, 1);
    checkOutput("rst_req_ready", Req_Ready, 0);
    Req_Valid = 1'b0;
    Req_Write = 1'b0;
    Req_BE    = 4'h0;
    @(posedge LMB_Clk);
    #1;
    LMB_Rst_N = 1'b1;
    #1;
    checkOutput("ready_after_release", Req_Ready, 1);
    checkOutput("bram_rst_released", BRAM_Rst, 0);

    // Read hit at an unaligned address of a preloaded word.
    applyStimulus(1'b1, 32'h100, 4'hF, 32'hDEADBEEF);
    applyStimulus(1'b0, 32'h102, 4'h0, 32'h0);
    @(negedge LMB_Clk);
    @(negedge LMB_Clk);
    checkOutput("read_hit_valid", Rsp_Valid, 1);
    checkOutput("read_hit_data", Rsp_RData, 32'hDEADBEEF);
    checkOutput("read_hit_err", Rsp_Err, 0);
    idle(3);

    // Single byte-lane write then read back.
    applyStimulus(1'b1, 32'h200, 4'b0010, 32'h11223344);
    applyStimulus(1'b0, 32'h200, 4'h0, 32'h0);
    @(negedge LMB_Clk);
    @(negedge LMB_Clk);
    checkOutput("byte_write_data", Rsp_RData, 32'h00003300);
    idle(3);

    // Out-of-range read and address-window edges.
    applyStimulus(1'b0, 32'h8000, 4'h0, 32'h0);
    @(negedge LMB_Clk);
    @(negedge LMB_Clk);
    checkOutput("oor_valid", Rsp_Valid, 1);
    checkOutput("oor_err", Rsp_Err, 1);
    checkOutput("oor_rdata", Rsp_RData, 0);
    idle(2);
    applyStimulus(1'b1, 32'h7FFF, 4'hF, 32'hCAFEF00D);
    applyStimulus(1'b0, 32'h7FFC, 4'h0, 32'h0);
    applyStimulus(1'b1, 32'hFFFF_FFFF, 4'hF, 32'h12345678);
    applyStimulus(1'b1, 32'h300, 4'h0, 32'hFFFFFFFF);
    applyStimulus(1'b0, 32'h300, 4'h0, 32'h0);
    idle(4);

    // Backpressure: two requests fit, the third waits for a pop.
    rdyMode = 0;
    idle(2);
    a0 = acceptCount;
    applyStimulus(1'b0, 32'h100, 4'h0, 32'h0);
    applyStimulus(1'b0, 32'h200, 4'h0, 32'h0);
    fork
      applyStimulus(1'b0, 32'h7FFC, 4'h0, 32'h0);
      begin
        repeat (4) @(negedge LMB_Clk);
        checkOutput("bp_accepts", acceptCount - a0, 2);
        checkOutput("bp_req_ready", Req_Ready, 0);
        checkOutput("bp_rsp_valid", Rsp_Valid, 1);
        @(posedge LMB_Clk);
        #1;
        rdyMode = 1;
      end
    join
    idle(5);
    checkOutput("bp_all_accepted", acceptCount - a0, 3);
    checkOutput("bp_queue_drained", expQ.size(), 0);

    // Streaming: eight back-to-back reads with the consumer always ready.
    acceptCycles.delete();
    rspCycles.delete();
    for (int i = 0; i < 8; i++) applyStimulus(1'b0, 32'h100 + 32'(4 * i), 4'h0, 32'h0);
    idle(6);
    checkOutput("stream_accepts", acceptCycles.size(), 8);
    checkOutput("stream_rsps", rspCycles.size(), 8);
    if (acceptCycles.size() == 8 && rspCycles.size() == 8) begin
      checkOutput("stream_accept_span", acceptCycles[7] - acceptCycles[0], 7);
      checkOutput("stream_rsp_span", rspCycles[7] - rspCycles[0], 7);
    end

    // Reset with two responses queued: they must vanish.
    rdyMode = 0;
    idle(1);
    applyStimulus(1'b0, 32'h100, 4'h0, 32'h0);
    applyStimulus(1'b0, 32'h200, 4'h0, 32'h0);
    idle(2);
    checkOutput("pre_reset_queued", Rsp_Valid, 1);
    @(negedge LMB_Clk);
    #2;
    LMB_Rst_N = 1'b0;
    #1;
    checkOutput("mid_reset_rsp_valid", Rsp_Valid, 0);
    checkOutput("mid_reset_rsp_err", Rsp_Err, 0);
    checkOutput("mid_reset_rsp_rdata", Rsp_RData, 0);
    checkOutput("mid_reset_bram_en", BRAM_EN, 0);
    idle(2);
    LMB_Rst_N = 1'b1;
    rdyMode = 1;
    r0 = rspCount;
    idle(5);
    checkOutput("no_stale_rsp", rspCount - r0, 0);

    // Request accepted in the very cycle reset asserts is discarded.
    Req_Valid = 1'b1;
    Req_Write = 1'b0;
    Req_Addr  = 32'h100;
    @(negedge LMB_Clk);
    checkOutput("accept_before_reset", Req_Ready, 1);
    #2;
    LMB_Rst_N = 1'b0;
    Req_Valid = 1'b0;
    idle(2);
    LMB_Rst_N = 1'b1;
    r0 = rspCount;
    idle(5);
    checkOutput("discard_on_reset", rspCount - r0, 0);

    // Randomized traffic with a randomly stalling consumer.
    rdyMode = 2;
    for (int n = 0; n < 300; n++) begin
      if ($urandom_range(3) == 0) idle($urandom_range(3, 1));
      r = $urandom_range(99);
      if (r < 70)      addr = $urandom_range(32'h3FF);
      else if (r < 82) addr = $urandom_range(32'h7FFF);
      else if (r < 88) addr = 32'h7FFC + $urandom_range(3);
      else if (r < 94) addr = 32'h8000 + $urandom_range(15);
      else             addr = $urandom();
      applyStimulus(1'($urandom_range(1)), addr, 4'($urandom_range(15)), $urandom());
    end
    rdyMode = 1;
    waitCyc = 0;
    while (expQ.size() != 0 && waitCyc < 100) begin
      idle(1);
      waitCyc++;
    end
    checkOutput("drain_empty", expQ.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
